// File: rtl/lab3_mem_cache_nway.sv
// Blocking write-back, write-allocate N-way set-associative cache with
// per-set true-LRU replacement. 4B processor messages, 16B memory messages.
`timescale 1ns/1ps
module lab3_mem_cache_nway #(
    parameter int unsigned p_num_banks = 1,
    parameter int unsigned p_num_ways  = 4,
    parameter int unsigned p_num_sets  = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [76:0]  proc2cache_reqstream_msg,
    input  logic         proc2cache_reqstream_val,
    output logic         proc2cache_reqstream_rdy,
    output logic [46:0]  proc2cache_respstream_msg,
    output logic         proc2cache_respstream_val,
    input  logic         proc2cache_respstream_rdy,
    output logic [174:0] cache2mem_reqstream_msg,
    output logic         cache2mem_reqstream_val,
    input  logic         cache2mem_reqstream_rdy,
    input  logic [144:0] cache2mem_respstream_msg,
    input  logic         cache2mem_respstream_val,
    output logic         cache2mem_respstream_rdy
);
    localparam int unsigned BANK_BITS = $clog2(p_num_banks);
    localparam int unsigned IDX_BITS  = $clog2(p_num_sets);
    localparam int unsigned WAY_BITS  = $clog2(p_num_ways);
    localparam logic [2:0]  TYPE_READ  = 3'd0;
    localparam logic [2:0]  TYPE_WRITE = 3'd1;
    localparam logic [2:0]  TYPE_INIT  = 3'd2;

    typedef enum logic [3:0] {
        IDLE, TAG_CHECK, INIT_DATA_ACCESS, READ_DATA_ACCESS, WRITE_DATA_ACCESS,
        EVICT_PREPARE, EVICT_REQUEST, EVICT_WAIT, REFILL_REQUEST, REFILL_WAIT,
        REFILL_UPDATE, WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            req_type_q, req_type_d;
    logic [7:0]            req_opaque_q, req_opaque_d;
    logic [31:0]           req_addr_q, req_addr_d;
    logic [31:0]           req_data_q, req_data_d;
    logic [WAY_BITS-1:0]   way_q, way_d;
    logic                  hit_q, hit_d;
    logic [31:0]           resp_data_q, resp_data_d;
    logic [27:0]           evict_tag_q, evict_tag_d;
    logic [127:0]          evict_line_q, evict_line_d;

    logic [27:0]           tag_q   [p_num_sets][p_num_ways];
    logic [27:0]           tag_d   [p_num_sets][p_num_ways];
    logic [127:0]          data_q  [p_num_sets][p_num_ways];
    logic [127:0]          data_d  [p_num_sets][p_num_ways];
    logic                  valid_q [p_num_sets][p_num_ways];
    logic                  valid_d [p_num_sets][p_num_ways];
    logic                  dirty_q [p_num_sets][p_num_ways];
    logic                  dirty_d [p_num_sets][p_num_ways];
    logic [WAY_BITS-1:0]   age_q   [p_num_sets][p_num_ways];
    logic [WAY_BITS-1:0]   age_d   [p_num_sets][p_num_ways];

    logic [IDX_BITS-1:0]   idx;
    logic [1:0]            word_sel;
    logic                  hit;
    logic [WAY_BITS-1:0]   hit_way;
    logic [WAY_BITS-1:0]   victim_way;
    logic                  found_inv;
    logic                  lru_en;
    logic                  unused_bits;

    assign idx         = req_addr_q[4 + BANK_BITS +: IDX_BITS];
    assign word_sel    = req_addr_q[3:2];
    assign unused_bits = ^{proc2cache_reqstream_msg[33:32], cache2mem_respstream_msg[144:128],
                           req_addr_q[1:0]};

    // Tag lookup and victim choice: lowest invalid way, else the oldest way
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        victim_way = '0;
        found_inv  = 1'b0;
        for (int unsigned w = 0; w < p_num_ways; w++) begin
            if (!hit && valid_q[idx][w] && tag_q[idx][w] == req_addr_q[31:4]) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!found_inv && !valid_q[idx][w]) begin
                found_inv  = 1'b1;
                victim_way = WAY_BITS'(w);
            end
        end
        if (!found_inv) begin
            for (int unsigned w = 0; w < p_num_ways; w++) begin
                if (age_q[idx][w] == WAY_BITS'(p_num_ways - 1)) victim_way = WAY_BITS'(w);
            end
        end
    end

    // Control FSM next state, array updates and handshake outputs
    always_comb begin
        state_d      = state_q;
        req_type_d   = req_type_q;
        req_opaque_d = req_opaque_q;
        req_addr_d   = req_addr_q;
        req_data_d   = req_data_q;
        way_d        = way_q;
        hit_d        = hit_q;
        resp_data_d  = resp_data_q;
        evict_tag_d  = evict_tag_q;
        evict_line_d = evict_line_q;
        tag_d        = tag_q;
        data_d       = data_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        age_d        = age_q;
        lru_en       = 1'b0;

        proc2cache_reqstream_rdy  = 1'b0;
        proc2cache_respstream_val = 1'b0;
        proc2cache_respstream_msg = '0;
        cache2mem_reqstream_val   = 1'b0;
        cache2mem_reqstream_msg   = '0;
        cache2mem_respstream_rdy  = 1'b0;

        case (state_q)
            IDLE: begin
                proc2cache_reqstream_rdy = reset;
                if (proc2cache_reqstream_val && reset) begin
                    req_type_d   = proc2cache_reqstream_msg[76:74];
                    req_opaque_d = proc2cache_reqstream_msg[73:66];
                    req_addr_d   = proc2cache_reqstream_msg[65:34];
                    req_data_d   = proc2cache_reqstream_msg[31:0];
                    state_d      = TAG_CHECK;
                end
            end
            TAG_CHECK: begin
                way_d = hit ? hit_way : victim_way;
                hit_d = hit && (req_type_q != TYPE_INIT);
                if (hit) begin
                    if (req_type_q == TYPE_INIT)       state_d = INIT_DATA_ACCESS;
                    else if (req_type_q == TYPE_WRITE) state_d = WRITE_DATA_ACCESS;
                    else                               state_d = READ_DATA_ACCESS;
                end else if (valid_q[idx][victim_way] && dirty_q[idx][victim_way]) begin
                    state_d = EVICT_PREPARE;
                end else if (req_type_q == TYPE_INIT) begin
                    state_d = INIT_DATA_ACCESS;
                end else begin
                    state_d = REFILL_REQUEST;
                end
            end
            EVICT_PREPARE: begin
                evict_tag_d  = tag_q[idx][way_q];
                evict_line_d = data_q[idx][way_q];
                state_d      = EVICT_REQUEST;
            end
            EVICT_REQUEST: begin
                cache2mem_reqstream_val = 1'b1;
                cache2mem_reqstream_msg = {TYPE_WRITE, 8'h00, evict_tag_q, 4'h0, 4'h0, evict_line_q};
                if (cache2mem_reqstream_rdy) state_d = EVICT_WAIT;
            end
            EVICT_WAIT: begin
                cache2mem_respstream_rdy = 1'b1;
                // an init miss only needed the dirty victim written back
                if (cache2mem_respstream_val)
                    state_d = (req_type_q == TYPE_INIT) ? INIT_DATA_ACCESS : REFILL_REQUEST;
            end
            REFILL_REQUEST: begin
                cache2mem_reqstream_val = 1'b1;
                cache2mem_reqstream_msg = {TYPE_READ, 8'h00, req_addr_q[31:4], 4'h0, 4'h0, 128'h0};
                if (cache2mem_reqstream_rdy) state_d = REFILL_WAIT;
            end
            REFILL_WAIT: begin
                cache2mem_respstream_rdy = 1'b1;
                if (cache2mem_respstream_val) begin
                    data_d[idx][way_q] = cache2mem_respstream_msg[127:0];
                    state_d            = REFILL_UPDATE;
                end
            end
            REFILL_UPDATE: begin
                tag_d[idx][way_q]   = req_addr_q[31:4];
                valid_d[idx][way_q] = 1'b1;
                dirty_d[idx][way_q] = 1'b0;
                state_d = (req_type_q == TYPE_WRITE) ? WRITE_DATA_ACCESS : READ_DATA_ACCESS;
            end
            READ_DATA_ACCESS: begin
                resp_data_d = data_q[idx][way_q][{word_sel, 5'b0} +: 32];
                lru_en      = 1'b1;
                state_d     = WAIT;
            end
            WRITE_DATA_ACCESS: begin
                data_d[idx][way_q][{word_sel, 5'b0} +: 32] = req_data_q;
                dirty_d[idx][way_q] = 1'b1;
                resp_data_d         = '0;
                lru_en              = 1'b1;
                state_d             = WAIT;
            end
            INIT_DATA_ACCESS: begin
                if (!(valid_q[idx][way_q] && tag_q[idx][way_q] == req_addr_q[31:4]))
                    data_d[idx][way_q] = '0;
                data_d[idx][way_q][{word_sel, 5'b0} +: 32] = req_data_q;
                tag_d[idx][way_q]   = req_addr_q[31:4];
                valid_d[idx][way_q] = 1'b1;
                dirty_d[idx][way_q] = 1'b0;
                resp_data_d         = '0;
                lru_en              = 1'b1;
                state_d             = WAIT;
            end
            WAIT: begin
                proc2cache_respstream_val = 1'b1;
                proc2cache_respstream_msg = {req_type_q, req_opaque_q, 1'b0, hit_q, 2'b00, resp_data_q};
                if (proc2cache_respstream_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // a refill is followed by a data access, so the touch happens once there
        if (lru_en) begin
            for (int unsigned w = 0; w < p_num_ways; w++) begin
                if (age_q[idx][w] < age_q[idx][way_q]) age_d[idx][w] = age_q[idx][w] + 1'b1;
            end
            age_d[idx][way_q] = '0;
        end
    end

    // State, request registers and line arrays
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_type_q   <= '0;
            req_opaque_q <= '0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            way_q        <= '0;
            hit_q        <= 1'b0;
            resp_data_q  <= '0;
            evict_tag_q  <= '0;
            evict_line_q <= '0;
            for (int unsigned s = 0; s < p_num_sets; s++) begin
                for (int unsigned w = 0; w < p_num_ways; w++) begin
                    tag_q[s][w]   <= '0;
                    data_q[s][w]  <= '0;
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_BITS'(w);
                end
            end
        end else begin
            state_q      <= state_d;
            req_type_q   <= req_type_d;
            req_opaque_q <= req_opaque_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
            way_q        <= way_d;
            hit_q        <= hit_d;
            resp_data_q  <= resp_data_d;
            evict_tag_q  <= evict_tag_d;
            evict_line_q <= evict_line_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            age_q        <= age_d;
        end
    end

endmodule

// File: tb/tb_lab3_mem_cache_nway.sv
// Directed bench for lab3_mem_cache_nway with a behavioural backing memory.
`timescale 1ns/1ps
module tb_lab3_mem_cache_nway;
    logic         clk = 1'b0;
    logic         reset;
    logic [76:0]  req_msg;
    logic         req_val, req_rdy;
    logic [46:0]  resp_msg;
    logic         resp_val, resp_rdy;
    logic [174:0] mreq_msg;
    logic         mreq_val, mreq_rdy;
    logic [144:0] mresp_msg;
    logic         mresp_val, mresp_rdy;

    int           total = 0;
    int           bad   = 0;
    int           mreq_cnt;
    int           last_lat;
    logic [7:0]   opq = 8'h00;
    logic         mem_hold;
    logic         pend;
    logic [144:0] pend_msg;
    logic [31:0]  ma;
    logic [127:0] mem  [0:4095];
    logic [174:0] mlog [0:31];

    always #5 clk = ~clk;
    assign mreq_rdy = 1'b1;

    lab3_mem_cache_nway #(.p_num_banks(1), .p_num_ways(4), .p_num_sets(8)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .proc2cache_reqstream_msg  (req_msg),
        .proc2cache_reqstream_val  (req_val),
        .proc2cache_reqstream_rdy  (req_rdy),
        .proc2cache_respstream_msg (resp_msg),
        .proc2cache_respstream_val (resp_val),
        .proc2cache_respstream_rdy (resp_rdy),
        .cache2mem_reqstream_msg   (mreq_msg),
        .cache2mem_reqstream_val   (mreq_val),
        .cache2mem_reqstream_rdy   (mreq_rdy),
        .cache2mem_respstream_msg  (mresp_msg),
        .cache2mem_respstream_val  (mresp_val),
        .cache2mem_respstream_rdy  (mresp_rdy)
    );

    // Backing memory: word at byte address A holds A, except lines 0x1000/0x2000
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4096; i++)
                mem[i] = {32'(i*16 + 12), 32'(i*16 + 8), 32'(i*16 + 4), 32'(i*16)};
            mem[12'h200] = {32'h0000000d, 32'h0000000c, 32'h0000000b, 32'h0000000a};
            mem[12'h100][31:0] = 32'hdeadbeef;
            mreq_cnt  = 0;
            pend      = 1'b0;
            mresp_val <= 1'b0;
            mresp_msg <= '0;
        end else begin
            if (mresp_val && mresp_rdy) begin
                mresp_val <= 1'b0;
            end else if (!mresp_val && pend && !mem_hold) begin
                mresp_val <= 1'b1;
                mresp_msg <= pend_msg;
                pend = 1'b0;
            end
            if (mreq_val && mreq_rdy) begin
                if (mreq_cnt < 32) mlog[mreq_cnt] = mreq_msg;
                mreq_cnt++;
                ma = mreq_msg[163:132];
                if (mreq_msg[174:172] == 3'd1) begin
                    mem[ma[15:4]] = mreq_msg[127:0];
                    pend_msg = {3'd1, 8'h00, 2'd0, 4'd0, 128'h0};
                end else begin
                    pend_msg = {3'd0, 8'h00, 2'd0, 4'd0, mem[ma[15:4]]};
                end
                pend = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        opq     = opq + 8'd1;
        req_msg = {t, opq, a, 2'd0, d};
        req_val = 1'b1;
        while (!req_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept", 64'(req_rdy), 64'd1);
        @(posedge clk);
        #1 req_val = 1'b0;
    endtask

    task automatic recv(output logic [46:0] r, output int lat);
        lat = 1;
        while (!resp_val && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("resp_seen", 64'(resp_val), 64'd1);
        r = resp_msg;
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input string nm, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] et, input logic [31:0] ed);
        logic [46:0] r;
        int          lat;
        send(t, a, d);
        recv(r, lat);
        last_lat = lat;
        chk({nm, ".type"}, 64'(r[46:44]), 64'(t));
        chk({nm, ".opq"},  64'(r[43:36]), 64'(opq));
        chk({nm, ".test"}, 64'(r[35:34]), 64'(et));
        chk({nm, ".len"},  64'(r[33:32]), 64'd0);
        chk({nm, ".data"}, 64'(r[31:0]),  64'(ed));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int          c0;
        int          n;
        logic [46:0] r0;
        reset    = 1'b1;
        req_val  = 1'b0;
        req_msg  = '0;
        resp_rdy = 1'b1;
        mem_hold = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req_rdy",   64'(req_rdy),   64'd0);
        chk("rst.resp_val",  64'(resp_val),  64'd0);
        chk("rst.mreq_val",  64'(mreq_val),  64'd0);
        chk("rst.mresp_rdy", 64'(mresp_rdy), 64'd0);
        chk("rst.resp_msg",  64'(resp_msg),  64'd0);
        chk("rst.mreq_addr", 64'(mreq_msg[163:132]), 64'd0);
        @(negedge clk) reset = 1'b1;
        #1 chk("rst.req_rdy_after", 64'(req_rdy), 64'd1);

        // 1: init then hit with 3-cycle latency, no memory traffic
        c0 = mreq_cnt;
        xact("t1.init", 3'd2, 32'h1000, 32'hdeadbeef, 2'd0, 32'h0);
        xact("t1.rd",   3'd0, 32'h1000, 32'h0, 2'd1, 32'hdeadbeef);
        chk("t1.lat",   64'(last_lat), 64'd3);
        chk("t1.nomem", 64'(mreq_cnt - c0), 64'd0);

        // 2: read miss refills line 0x2000, then a hit on another word
        c0 = mreq_cnt;
        xact("t2.miss", 3'd0, 32'h2004, 32'h0, 2'd0, 32'h0000000b);
        chk("t2.nreq",  64'(mreq_cnt - c0), 64'd1);
        chk("t2.rtype", 64'(mlog[c0][174:172]), 64'd0);
        chk("t2.raddr", 64'(mlog[c0][163:132]), 64'h2000);
        xact("t2.hit",  3'd0, 32'h2008, 32'h0, 2'd1, 32'h0000000c);
        chk("t2.lat",   64'(last_lat), 64'd3);

        // 3: fill set 0, touch 0x0000, then 0x0200 replaces LRU way (0x0080)
        do_reset();
        xact("t3.f0", 3'd0, 32'h0000, 32'h0, 2'd0, 32'h0000);
        xact("t3.f1", 3'd0, 32'h0080, 32'h0, 2'd0, 32'h0080);
        xact("t3.f2", 3'd0, 32'h0100, 32'h0, 2'd0, 32'h0100);
        xact("t3.f3", 3'd0, 32'h0180, 32'h0, 2'd0, 32'h0180);
        xact("t3.h0", 3'd0, 32'h0000, 32'h0, 2'd1, 32'h0000);
        c0 = mreq_cnt;
        xact("t3.new", 3'd0, 32'h0200, 32'h0, 2'd0, 32'h0200);
        chk("t3.nreq",  64'(mreq_cnt - c0), 64'd1);
        chk("t3.raddr", 64'(mlog[c0][163:132]), 64'h0200);
        xact("t3.keep", 3'd0, 32'h0000, 32'h0, 2'd1, 32'h0000);
        xact("t3.gone", 3'd0, 32'h0080, 32'h0, 2'd0, 32'h0080);

        // 4: dirty line 0x0000 written back before refill of 0x0200
        do_reset();
        xact("t4.wr", 3'd1, 32'h0004, 32'h11, 2'd0, 32'h0);
        xact("t4.f1", 3'd0, 32'h0080, 32'h0, 2'd0, 32'h0080);
        xact("t4.f2", 3'd0, 32'h0100, 32'h0, 2'd0, 32'h0100);
        xact("t4.f3", 3'd0, 32'h0180, 32'h0, 2'd0, 32'h0180);
        c0 = mreq_cnt;
        xact("t4.new", 3'd0, 32'h0200, 32'h0, 2'd0, 32'h0200);
        chk("t4.nreq",   64'(mreq_cnt - c0), 64'd2);
        chk("t4.etype",  64'(mlog[c0][174:172]), 64'd1);
        chk("t4.eopq",   64'(mlog[c0][171:164]), 64'd0);
        chk("t4.eaddr",  64'(mlog[c0][163:132]), 64'h0000);
        chk("t4.elen",   64'(mlog[c0][131:128]), 64'd0);
        chk("t4.eword0", 64'(mlog[c0][31:0]),  64'h0);
        chk("t4.eword1", 64'(mlog[c0][63:32]), 64'h11);
        chk("t4.eword2", 64'(mlog[c0][95:64]), 64'h8);
        chk("t4.rtype",  64'(mlog[c0 + 1][174:172]), 64'd0);
        chk("t4.raddr",  64'(mlog[c0 + 1][163:132]), 64'h0200);
        xact("t4.back", 3'd0, 32'h0004, 32'h0, 2'd0, 32'h11);

        // 5: hold resp_rdy low for 5 cycles on a hit
        resp_rdy = 1'b0;
        send(3'd0, 32'h0008, 32'h0);
        n = 0;
        while (!resp_val && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        r0 = resp_msg;
        chk("t5.val0", 64'(resp_val), 64'd1);
        chk("t5.test", 64'(r0[35:34]), 64'd1);
        chk("t5.data", 64'(r0[31:0]), 64'h8);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("t5.stable", 64'(resp_msg), 64'(r0));
            chk("t5.val",    64'(resp_val), 64'd1);
            chk("t5.reqrdy", 64'(req_rdy), 64'd0);
        end
        resp_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("t5.done_val", 64'(resp_val), 64'd0);
        chk("t5.done_rdy", 64'(req_rdy), 64'd1);

        // 6: reset while waiting for a refill response
        mem_hold = 1'b1;
        c0 = mreq_cnt;
        send(3'd0, 32'h3000, 32'h0);
        n = 0;
        while (mreq_cnt == c0 && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("t6.nreq",     64'(mreq_cnt - c0), 64'd1);
        chk("t6.in_wait",  64'(mresp_rdy), 64'd1);
        reset = 1'b0;
        #1;
        chk("t6.resp_val",  64'(resp_val),  64'd0);
        chk("t6.mreq_val",  64'(mreq_val),  64'd0);
        chk("t6.mresp_rdy", 64'(mresp_rdy), 64'd0);
        chk("t6.req_rdy",   64'(req_rdy),   64'd0);
        chk("t6.resp_msg",  64'(resp_msg),  64'd0);
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b1;
        mem_hold = 1'b0;
        xact("t6.after", 3'd0, 32'h0004, 32'h0, 2'd0, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
